// File: rtl/uart_cmd_responder.sv
// Command endpoint of the UART link: decodes write/read frames into register-file
// strobes and returns read data through the transmitter's parallel handshake.
module uart_cmd_responder #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    RD_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  WR_EN,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  RD_EN,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  RD_DATA_VLD,
    output logic                  CMD_ERR
);

    localparam int                CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_TX_WAIT
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt, tx_data_nxt;
    logic                    wr_en_nxt, rd_en_nxt, tx_vld_nxt, err_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ADDR      <= '0;
            WR_DATA   <= '0;
            TX_P_DATA <= '0;
            WR_EN     <= 1'b0;
            RD_EN     <= 1'b0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ADDR      <= addr_nxt;
            WR_DATA   <= wr_data_nxt;
            TX_P_DATA <= tx_data_nxt;
            WR_EN     <= wr_en_nxt;
            RD_EN     <= rd_en_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            CMD_ERR   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = ADDR;
        wr_data_nxt = WR_DATA;
        tx_data_nxt = TX_P_DATA;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        tx_vld_nxt  = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD)      state_nxt = S_WR_ADDR;
                    else if (RX_P_DATA == RD_CMD) state_nxt = S_RD_ADDR;
                    else                          err_nxt   = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // A byte arriving mid-read is discarded; the read itself carries on.
                err_nxt = RX_D_VLD;
                cnt_nxt = cnt + CNT_W'(1);
                if (RD_DATA_VLD) begin
                    tx_data_nxt = RD_DATA;
                    if (TX_BUSY) begin
                        state_nxt = S_TX_WAIT;
                    end else begin
                        tx_vld_nxt = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_TX_WAIT: begin
                err_nxt = RX_D_VLD;
                if (!TX_BUSY) begin
                    tx_vld_nxt = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: directed protocol scenarios with literal expectations,
// then random traffic checked every cycle against a frame-level reference model.
module tb_uart_cmd_responder;

    localparam int         DW  = 8;
    localparam int         AW  = 4;
    localparam logic [7:0] WRC = 8'hAA;
    localparam logic [7:0] RDC = 8'hBB;
    localparam int         TO  = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic          TX_BUSY = 1'b0;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic [AW-1:0] ADDR;
    logic          WR_EN;
    logic [DW-1:0] WR_DATA;
    logic          RD_EN;
    logic [DW-1:0] RD_DATA = '0;
    logic          RD_DATA_VLD = 1'b0;
    logic          CMD_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    uart_cmd_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WR_CMD(WRC), .RD_CMD(RDC), .RD_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .TX_BUSY(TX_BUSY),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .ADDR(ADDR), .WR_EN(WR_EN),
        .WR_DATA(WR_DATA), .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects frame bytes in a queue and tracks an outstanding read.
    logic [7:0]    frame_q[$];
    bit            rd_pending = 0;
    bit            tx_hold    = 0;
    int            rd_age     = 0;
    bit            model_ok   = 0;
    logic [AW-1:0] m_addr     = '0;
    logic [7:0]    m_wr_data  = '0;
    logic [7:0]    m_tx_data  = '0;
    bit            m_wr_en = 0, m_rd_en = 0, m_tx_vld = 0, m_err = 0;

    always @(posedge CLK) begin
        m_wr_en = 0; m_rd_en = 0; m_tx_vld = 0; m_err = 0;
        if (RST) begin
            model_ok  = 1;
            frame_q.delete();
            rd_pending = 0; tx_hold = 0; rd_age = 0;
            m_addr = '0; m_wr_data = '0; m_tx_data = '0;
        end else if (rd_pending || tx_hold) begin
            if (RX_D_VLD) m_err = 1;
            if (rd_pending) begin
                if (RD_DATA_VLD) begin
                    m_tx_data  = RD_DATA;
                    rd_pending = 0;
                    if (TX_BUSY) tx_hold = 1;
                    else         m_tx_vld = 1;
                end else if (rd_age == TO - 1) begin
                    m_err      = 1;
                    rd_pending = 0;
                end else begin
                    rd_age++;
                end
            end else if (!TX_BUSY) begin
                m_tx_vld = 1;
                tx_hold  = 0;
            end
        end else if (RX_D_VLD) begin
            frame_q.push_back(RX_P_DATA);
            if (frame_q[0] == WRC) begin
                if (frame_q.size() == 2) m_addr = frame_q[1][AW-1:0];
                if (frame_q.size() == 3) begin
                    m_wr_en   = 1;
                    m_wr_data = frame_q[2];
                    frame_q.delete();
                end
            end else if (frame_q[0] == RDC) begin
                if (frame_q.size() == 2) begin
                    m_addr     = frame_q[1][AW-1:0];
                    m_rd_en    = 1;
                    rd_pending = 1;
                    rd_age     = 0;
                    frame_q.delete();
                end
            end else begin
                m_err = 1;
                frame_q.delete();
            end
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            check("model_wr_en",   8'(WR_EN),    8'(m_wr_en));
            check("model_rd_en",   8'(RD_EN),    8'(m_rd_en));
            check("model_tx_vld",  8'(TX_D_VLD), 8'(m_tx_vld));
            check("model_cmd_err", 8'(CMD_ERR),  8'(m_err));
            check("model_addr",    8'(ADDR),     8'(m_addr));
            check("model_wr_data", WR_DATA,      m_wr_data);
            check("model_tx_data", TX_P_DATA,    m_tx_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        RD_DATA     = d;
        RD_DATA_VLD = 1'b1;
        tick(1);
        RD_DATA_VLD = 1'b0;
    endtask

    initial begin
        logic [1:0] sel;
        tick(2);
        check("reset_wr_en",   8'(WR_EN),    8'h0);
        check("reset_tx_vld",  8'(TX_D_VLD), 8'h0);
        check("reset_addr",    8'(ADDR),     8'h0);
        RST = 1'b0;
        tick(1);

        // Write frame
        send(8'hAA); send(8'h05); send(8'h3C);
        check("wr_en",   8'(WR_EN),   8'h1);
        check("wr_addr", 8'(ADDR),    8'h05);
        check("wr_data", WR_DATA,     8'h3C);
        check("wr_err",  8'(CMD_ERR), 8'h0);
        tick(1);
        check("wr_en_single", 8'(WR_EN), 8'h0);

        // Read, transmitter idle
        send(8'hBB); send(8'h0A);
        check("rd_en",   8'(RD_EN), 8'h1);
        check("rd_addr", 8'(ADDR),  8'h0A);
        tick(3);
        pulse_rd(8'h5A);
        check("rd_tx_vld",  8'(TX_D_VLD), 8'h1);
        check("rd_tx_data", TX_P_DATA,    8'h5A);
        tick(1);
        check("rd_tx_single", 8'(TX_D_VLD), 8'h0);

        // Read, transmitter busy on return
        send(8'hBB); send(8'h07);
        tick(2);
        TX_BUSY = 1'b1;
        pulse_rd(8'h77);
        check("busy_no_tx", 8'(TX_D_VLD), 8'h0);
        tick(9);
        check("busy_still_no_tx", 8'(TX_D_VLD), 8'h0);
        TX_BUSY = 1'b0;
        tick(1);
        check("busy_tx_vld",  8'(TX_D_VLD), 8'h1);
        check("busy_tx_data", TX_P_DATA,    8'h77);
        tick(1);
        check("busy_tx_single", 8'(TX_D_VLD), 8'h0);

        // Read timeout
        send(8'hBB); send(8'h03);
        tick(TO - 1);
        check("to_not_yet", 8'(CMD_ERR), 8'h0);
        tick(1);
        check("to_err",   8'(CMD_ERR),  8'h1);
        check("to_no_tx", 8'(TX_D_VLD), 8'h0);
        tick(1);
        check("to_err_single", 8'(CMD_ERR), 8'h0);
        send(8'hAA); send(8'h01); send(8'hFF);
        check("after_to_wr_en",   8'(WR_EN), 8'h1);
        check("after_to_addr",    8'(ADDR),  8'h01);
        check("after_to_wr_data", WR_DATA,   8'hFF);

        // Protocol errors
        tick(1);
        send(8'h12);
        check("idle_err",   8'(CMD_ERR), 8'h1);
        check("idle_no_wr", 8'(WR_EN),   8'h0);
        send(8'hBB); send(8'h04);
        tick(1);
        send(8'h55);
        check("rdwait_err", 8'(CMD_ERR), 8'h1);
        pulse_rd(8'h9C);
        check("rdwait_tx_vld",  8'(TX_D_VLD), 8'h1);
        check("rdwait_tx_data", TX_P_DATA,    8'h9C);

        // Reset mid-frame
        tick(1);
        send(8'hAA); send(8'h02);
        RST = 1'b1;
        tick(1);
        check("rst_addr",    8'(ADDR),    8'h0);
        check("rst_tx_data", TX_P_DATA,   8'h0);
        check("rst_wr_data", WR_DATA,     8'h0);
        check("rst_err",     8'(CMD_ERR), 8'h0);
        RST = 1'b0;
        send(8'h99);
        check("post_rst_err",   8'(CMD_ERR), 8'h1);
        check("post_rst_no_wr", 8'(WR_EN),   8'h0);
        tick(1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RST      = ($urandom_range(0, 299) == 0);
            RX_D_VLD = ($urandom_range(0, 9) < 3);
            sel      = 2'($urandom_range(0, 3));
            RX_P_DATA = (sel == 2'd0) ? WRC : (sel == 2'd1) ? RDC : 8'($urandom);
            RD_DATA_VLD = ($urandom_range(0, 99) < 10);
            RD_DATA     = 8'($urandom);
            if ($urandom_range(0, 7) == 0) TX_BUSY = ~TX_BUSY;
            tick(1);
        end
        RST = 1'b0; RX_D_VLD = 1'b0; RD_DATA_VLD = 1'b0; TX_BUSY = 1'b0;
        tick(TO + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
